uart_tx_fifo_reader: RTL

UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx_fifo_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_e      : FSM states of the FIFO-reading transmitter
//   DefaultClksPerBit : default clk cycles per serial bit
//   ParityEven/Odd    : values for the PARITY_ODD parameter
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StStart  = 3'd2,
        StData   = 3'd3,
        StParity = 3'd4,
        StStop   = 3'd5
    } uart_state_e;

    localparam int unsigned DefaultClksPerBit = 16;

    localparam int unsigned ParityEven = 0;
    localparam int unsigned ParityOdd  = 1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; clr holds it at zero.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : hold counter at zero
//   cnt  : current count
//   last : high on the final cycle of a bit period
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pulls bytes from an upstream synchronous FIFO.
// Frame: FETCH (1 clk), start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit; each serial bit lasts CLKS_PER_BIT clks.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   fifo_empty : upstream FIFO empty flag
//   fifo_data  : FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : single-cycle pop request (registered)
//   tx         : serial line, idle high (registered)
//   busy       : high whenever the FSM is not idle
//   tx_done    : one-cycle pulse on the last clk of each stop bit
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = ParityEven
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] PreLastCnt = CntW'(CLKS_PER_BIT - 2);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IdxW-1:0]       bit_idx_q;
    logic                  parity_q;

    logic [CntW-1:0] baud_cnt;
    logic            baud_last;
    logic            baud_clr;
    logic            baud_pre_last;

    // Bit-period states leave only on baud_last, where the counter wraps to
    // zero by itself; the other states hold it cleared so every state change
    // starts a fresh bit period.
    assign baud_clr      = (state_q == StIdle) || (state_q == StFetch);
    assign baud_pre_last = (baud_cnt == PreLastCnt);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CntW)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .cnt  (baud_cnt),
        .last (baud_last)
    );

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx <= 1'b1;
                    // Pop first, then enter FETCH once the pop is on the bus,
                    // so the registered read data is valid during FETCH.
                    if (fifo_rd_en) begin
                        state_q <= StFetch;
                    end else if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                    end
                end
                StFetch: begin
                    shift_q   <= fifo_data;
                    parity_q  <= (^fifo_data) ^ (PARITY_ODD != 0);
                    bit_idx_q <= '0;
                    tx        <= 1'b0;
                    state_q   <= StStart;
                end
                StStart: begin
                    if (baud_last) begin
                        tx      <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        if (bit_idx_q == LastIdx) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx      <= parity_q;
                                state_q <= StParity;
                            end else begin
                                tx      <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx        <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                StParity: begin
                    if (baud_last) begin
                        tx      <= 1'b1;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    // Registered outputs are set one cycle early so tx_done and
                    // the next pop both appear on the last stop-bit clk.
                    if (baud_pre_last) begin
                        tx_done    <= 1'b1;
                        fifo_rd_en <= !fifo_empty;
                    end
                    if (baud_last) begin
                        state_q <= fifo_rd_en ? StFetch : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
